// File: rtl/hack_pkg.sv
// hack_pkg: shared types and instruction field positions for the HACK control unit.
// The HALT state exists only when HACK_CTRL_HALT_EN is defined.
package hack_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MREAD,
    ST_EXEC,
    ST_MWRITE
`ifdef HACK_CTRL_HALT_EN
    ,
    ST_HALT
`endif
  } state_t;

  // C-instruction field positions
  localparam int A_BIT = 12;
  localparam int C_MSB = 11;
  localparam int C_LSB = 6;
  localparam int D_A   = 5;
  localparam int D_D   = 4;
  localparam int D_M   = 3;
  localparam int J_LT  = 2;
  localparam int J_EQ  = 1;
  localparam int J_GT  = 0;

  localparam logic [14:0] RESET_PC = 15'h0000;

endpackage

// File: rtl/hack_ctrl_if.sv
// hack_ctrl_if: instruction port, data port and ALU connection of the HACK control unit.
// master = control unit side, slave = ROM/RAM/ALU side.
interface hack_ctrl_if;
  logic        imem_req;
  logic [14:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;

  logic        dmem_req;
  logic        dmem_we;
  logic [14:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;

  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;

  modport master (
    output imem_req, imem_addr, input imem_ack, imem_data,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_ack, dmem_rdata,
    output alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
    input  alu_out, alu_zr, alu_ng
  );

  modport slave (
    input  imem_req, imem_addr, output imem_ack, imem_data,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_ack, dmem_rdata,
    input  alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
    output alu_out, alu_zr, alu_ng
  );
endinterface

// File: rtl/hack_jump_unit.sv
// hack_jump_unit: combinational jump decision from the j field and the ALU flags.
module hack_jump_unit
  import hack_pkg::*;
(
  input  logic [2:0] j,
  input  logic       zr,
  input  logic       ng,
  output logic       taken
);
  assign taken = (j[J_LT] & ng) | (j[J_EQ] & zr) | (j[J_GT] & ~ng & ~zr);
endmodule

// File: rtl/hack_ctrl.sv
// hack_ctrl: multi-cycle HACK CPU control unit (fetch, decode, M read, execute, M write).
// Define HACK_CTRL_HALT_EN to detect the "@n; jump to n" halt loop and stop in HALT.
module hack_ctrl
  import hack_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  hack_ctrl_if.master bus,
  output logic [14:0] pc,
  output logic        halted
);

  state_t      state, state_next;
  logic [15:0] a_reg, d_reg, ir, m_reg, r_reg;
  logic [14:0] pc_reg, a_shadow;
  logic [14:0] pc_inc;
  logic        taken;
  logic        imem_req, dmem_req, dmem_we;
  logic [14:0] dmem_addr;
  logic [5:0]  alu_ctrl;

  assign pc_inc = pc_reg + 15'd1;

  hack_jump_unit u_jump (
    .j     (ir[J_LT:J_GT]),
    .zr    (bus.alu_zr),
    .ng    (bus.alu_ng),
    .taken (taken)
  );

`ifdef HACK_CTRL_HALT_EN
  logic last_a;
  logic halt_hit;

  // Remember whether the instruction before the current one was an A-instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_a <= 1'b0;
    end else if (state == ST_DECODE && !ir[15]) begin
      last_a <= 1'b1;
    end else if (state == ST_EXEC) begin
      last_a <= 1'b0;
    end
  end

  // "@n" followed by a taken jump back to that "@n" spins forever
  assign halt_hit = taken && last_a && (a_reg[14:0] == 15'(pc_reg - 15'd1));
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH:  if (bus.imem_ack) state_next = ST_DECODE;
      ST_DECODE: begin
        if (!ir[15])          state_next = ST_FETCH;
        else if (ir[A_BIT])   state_next = ST_MREAD;
        else                  state_next = ST_EXEC;
      end
      ST_MREAD:  if (bus.dmem_ack) state_next = ST_EXEC;
      ST_EXEC: begin
        state_next = ir[D_M] ? ST_MWRITE : ST_FETCH;
`ifdef HACK_CTRL_HALT_EN
        if (halt_hit) state_next = ST_HALT;
`endif
      end
      ST_MWRITE: if (bus.dmem_ack) state_next = ST_FETCH;
      default:   state_next = state;
    endcase
  end

  // Architectural and holding registers, updated per state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      d_reg    <= '0;
      pc_reg   <= RESET_PC;
      ir       <= '0;
      m_reg    <= '0;
      r_reg    <= '0;
      a_shadow <= '0;
    end else begin
      case (state)
        ST_FETCH:  if (bus.imem_ack) ir <= bus.imem_data;
        ST_DECODE: begin
          if (!ir[15]) begin
            a_reg  <= {1'b0, ir[14:0]};
            pc_reg <= pc_inc;
          end
        end
        ST_MREAD:  if (bus.dmem_ack) m_reg <= bus.dmem_rdata;
        ST_EXEC: begin
          // NOTE: non-blocking assignments all read the pre-edge A, so the shadow
          // copy and the jump target both see A as it was before this instruction.
          r_reg    <= bus.alu_out;
          a_shadow <= a_reg[14:0];
          if (ir[D_A]) a_reg <= bus.alu_out;
          if (ir[D_D]) d_reg <= bus.alu_out;
          pc_reg   <= taken ? a_reg[14:0] : pc_inc;
        end
        default: ;
      endcase
    end
  end

  // Output decode from the state register only (no ack-to-req path)
  always_comb begin
    // NOTE: defaults first so no branch of the case leaves an output unassigned (no latch).
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    dmem_addr = a_reg[14:0];
    alu_ctrl  = 6'b000000;
    case (state)
      ST_FETCH:  imem_req = 1'b1;
      ST_MREAD:  dmem_req = 1'b1;
      ST_EXEC:   alu_ctrl = ir[C_MSB:C_LSB];
      ST_MWRITE: begin
        dmem_req  = 1'b1;
        dmem_we   = 1'b1;
        dmem_addr = a_shadow;
      end
      default: ;
    endcase
  end

  // The reset state is FETCH, but no fetch is requested while reset is held
  assign bus.imem_req   = imem_req & rst_n;
  assign bus.imem_addr  = pc_reg;
  assign bus.dmem_req   = dmem_req;
  assign bus.dmem_we    = dmem_we;
  assign bus.dmem_addr  = dmem_addr;
  assign bus.dmem_wdata = r_reg;
  assign bus.alu_x      = d_reg;
  assign bus.alu_y      = ir[A_BIT] ? m_reg : a_reg;
  assign {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no} = alu_ctrl;
  assign pc             = pc_reg;

`ifdef HACK_CTRL_HALT_EN
  assign halted = (state == ST_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_hack_ctrl.sv
// tb_hack_ctrl: bench for hack_ctrl with ROM/RAM responders, a behavioural ALU and an
// instruction-level HACK model used as scoreboard.
module tb_hack_ctrl;

`ifdef HACK_CTRL_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] pc;
  logic        halted;

  hack_ctrl_if bus ();

  hack_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .pc     (pc),
    .halted (halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Program and data memory seen by the responders
  logic [15:0] rom [logic [14:0]];
  logic [15:0] ram [logic [14:0]];
  int imem_fix = -1;
  int dmem_fix = -1;
  int icnt = 0, dcnt = 0, iwait = 0, dwait = 0;

  // Reference model state
  logic [15:0] m_a, m_d;
  logic [14:0] m_pc;
  bit          m_last_a, m_halted;
  logic [15:0] mram [logic [14:0]];
  logic [30:0] exp_wr [$];
  logic [14:0] exp_rd [$];
  logic [14:0] fetch_log [$];
  logic [5:0]  ctrl_log [$];
  bit          mon_en = 1'b0;
  bit          mon_done = 1'b0;
  int          n_fetch = 0, n_target = 0, n_wr = 0;
  logic [14:0] last_wr_addr;
  logic [15:0] last_wr_data;

  function automatic logic [15:0] rom_rd(input logic [14:0] a);
    return rom.exists(a) ? rom[a] : 16'h0000;
  endfunction

  function automatic logic [15:0] ram_rd(input logic [14:0] a);
    return ram.exists(a) ? ram[a] : 16'h0000;
  endfunction

  function automatic logic [15:0] mram_rd(input logic [14:0] a);
    return mram.exists(a) ? mram[a] : 16'h0000;
  endfunction

  // HACK ALU: c = {zx, nx, zy, ny, f, no}
  function automatic logic [15:0] alu_fn(input logic [15:0] x, input logic [15:0] y,
                                         input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0000 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'h0000 : y;
    if (c[2]) yy = ~yy;
    o = c[1] ? xx + yy : xx & yy;
    if (c[0]) o = ~o;
    return o;
  endfunction

  always_comb begin
    logic [15:0] o;
    o = alu_fn(bus.alu_x, bus.alu_y,
               {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no});
    bus.alu_out = o;
    bus.alu_zr  = (o == 16'h0000);
    bus.alu_ng  = o[15];
  end

  // Execute one whole instruction at the ISA level
  task automatic model_step(input logic [15:0] ins);
    logic [15:0] y, o;
    logic [14:0] old_a;
    bit          zr, ng, tk, hlt;
    if (!ins[15]) begin
      m_a      = {1'b0, ins[14:0]};
      m_pc     = m_pc + 15'd1;
      m_last_a = 1'b1;
      return;
    end
    old_a = m_a[14:0];
    if (ins[12]) begin
      exp_rd.push_back(old_a);
      y = mram_rd(old_a);
    end else begin
      y = m_a;
    end
    o   = alu_fn(m_d, y, ins[11:6]);
    zr  = (o == 16'h0000);
    ng  = o[15];
    tk  = (ins[2] && ng) || (ins[1] && zr) || (ins[0] && !ng && !zr);
    hlt = HALT_EN && tk && m_last_a && (old_a == 15'(m_pc - 15'd1));
    if (ins[5]) m_a = o;
    if (ins[4]) m_d = o;
    if (ins[3] && !hlt) begin
      exp_wr.push_back({old_a, o});
      mram[old_a] = o;
    end
    m_pc     = tk ? old_a : m_pc + 15'd1;
    m_last_a = 1'b0;
    m_halted = hlt;
  endtask

  // Scoreboard: compare every memory transaction and every fetch with the model
  task automatic monitor_cycle();
    logic [5:0]  ctrl;
    logic [30:0] e;
    logic [14:0] ea;
    ctrl = {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no};
    if (ctrl != 6'b000000) ctrl_log.push_back(ctrl);
    if (bus.dmem_req && bus.dmem_ack) begin
      checks++;
      if (bus.dmem_we) begin
        n_wr++;
        last_wr_addr = bus.dmem_addr;
        last_wr_data = bus.dmem_wdata;
        if (exp_wr.size() == 0) begin
          failures++;
          $display("FAIL dmem_write: unexpected write addr=%h data=%h", bus.dmem_addr, bus.dmem_wdata);
        end else begin
          e = exp_wr.pop_front();
          if ({bus.dmem_addr, bus.dmem_wdata} !== e) begin
            failures++;
            $display("FAIL dmem_write: got addr=%h data=%h, expected addr=%h data=%h",
                     bus.dmem_addr, bus.dmem_wdata, e[30:16], e[15:0]);
          end
        end
      end else begin
        if (exp_rd.size() == 0) begin
          failures++;
          $display("FAIL dmem_read: unexpected read addr=%h", bus.dmem_addr);
        end else begin
          ea = exp_rd.pop_front();
          if (bus.dmem_addr !== ea) begin
            failures++;
            $display("FAIL dmem_read: got addr=%h, expected %h", bus.dmem_addr, ea);
          end
        end
      end
    end
    if (bus.imem_req && bus.imem_ack) begin
      n_fetch++;
      fetch_log.push_back(bus.imem_addr);
      checks++;
      if (bus.imem_addr !== m_pc) begin
        failures++;
        $display("FAIL fetch_pc: fetch #%0d got %h, expected %h", n_fetch, bus.imem_addr, m_pc);
      end
      checks++;
      if (bus.alu_x !== m_d) begin
        failures++;
        $display("FAIL d_reg: at fetch #%0d got %h, expected %h", n_fetch, bus.alu_x, m_d);
      end
      if (n_fetch >= n_target) begin
        mon_done = 1'b1;
        mon_en   = 1'b0;
      end else begin
        model_step(rom_rd(m_pc));
      end
    end
  endtask

  // ROM/RAM responders with programmable or random ack delay, then the scoreboard
  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_data  = 16'h0000;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (bus.imem_req) begin
        if (icnt == 0) iwait = (imem_fix >= 0) ? imem_fix : int'($urandom_range(0, 2));
        bus.imem_ack  = (icnt >= iwait);
        bus.imem_data = rom_rd(bus.imem_addr);
        icnt = bus.imem_ack ? 0 : icnt + 1;
      end else begin
        icnt = 0;
        bus.imem_ack = 1'b0;
      end
      if (bus.dmem_req) begin
        if (dcnt == 0) dwait = (dmem_fix >= 0) ? dmem_fix : int'($urandom_range(0, 2));
        bus.dmem_ack   = (dcnt >= dwait);
        bus.dmem_rdata = ram_rd(bus.dmem_addr);
        if (bus.dmem_ack && bus.dmem_we) ram[bus.dmem_addr] = bus.dmem_wdata;
        dcnt = bus.dmem_ack ? 0 : dcnt + 1;
      end else begin
        dcnt = 0;
        bus.dmem_ack = 1'b0;
      end
      if (mon_en) monitor_cycle();
    end
  end

  task automatic start_run(input int n);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    m_a = '0; m_d = '0; m_pc = '0; m_last_a = 1'b0; m_halted = 1'b0;
    mram = ram;
    exp_wr.delete(); exp_rd.delete(); fetch_log.delete(); ctrl_log.delete();
    n_fetch = 0; n_target = n; n_wr = 0; mon_done = 1'b0;
    #2;
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic wait_done(input int budget, input string name);
    int cyc = 0;
    while (!mon_done && !m_halted && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!mon_done && !m_halted) begin
      failures++;
      $display("FAIL %s_timeout: %0d fetches after %0d cycles, expected %0d", name, n_fetch, cyc, n_target);
    end
    if (m_halted) repeat (10) @(negedge clk);
    checks++;
    if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
      failures++;
      $display("FAIL %s_pending: %0d writes and %0d reads never seen", name, exp_wr.size(), exp_rd.size());
    end
    mon_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (pc !== 15'h0000) begin failures++; $display("FAIL reset_pc: got %h, expected 0000", pc); end
    checks++;
    if (bus.imem_req !== 1'b0 || bus.dmem_req !== 1'b0 || bus.dmem_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_req: imem_req=%b dmem_req=%b dmem_we=%b, expected 0 0 0",
               bus.imem_req, bus.dmem_req, bus.dmem_we);
    end
    checks++;
    if ({bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no} !== 6'b000000) begin
      failures++;
      $display("FAIL reset_alu_ctrl: got nonzero control bits, expected 000000");
    end
    checks++;
    if (halted !== 1'b0 || bus.alu_x !== 16'h0000 || bus.alu_y !== 16'h0000) begin
      failures++;
      $display("FAIL reset_regs: halted=%b alu_x=%h alu_y=%h, expected 0 0000 0000",
               halted, bus.alu_x, bus.alu_y);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 15'h0000) begin
      failures++;
      $display("FAIL reset_first_fetch: imem_req=%b addr=%h, expected 1 0000", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_fetch_delay();
    int cnt = 0;
    rom.delete(); ram.delete();
    rom[0] = 16'h0005;  // @5
    rom[1] = 16'hEC10;  // D=A
    rom[2] = 16'h0007;  // @7
    rom[3] = 16'hEC10;  // D=A
    rom[4] = 16'h0064;  // @100
    rom[5] = 16'hE7C8;  // M=D+1
    imem_fix = 3;
    start_run(7);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_addr == 15'h0000) cnt++;
      else break;
    end
    imem_fix = -1;
    checks++;
    if (cnt !== 4) begin failures++; $display("FAIL fetch_hold: req high %0d cycles, expected 4", cnt); end
    wait_done(400, "fetch_delay");
    checks++;
    if (fetch_log.size() < 2 || fetch_log[1] !== 15'd1) begin
      failures++;
      $display("FAIL a_inst_pc: second fetch address wrong, expected 0001");
    end
    checks++;
    if (ctrl_log.size() == 0 || ctrl_log[0] !== 6'b110000) begin
      failures++;
      $display("FAIL d_eq_a_ctrl: got %b, expected 110000", ctrl_log.size() ? ctrl_log[0] : 6'b0);
    end
    checks++;
    if (n_wr !== 1 || last_wr_addr !== 15'd100 || last_wr_data !== 16'd8) begin
      failures++;
      $display("FAIL m_store: writes=%0d addr=%0d data=%0d, expected 1 100 8", n_wr, last_wr_addr, last_wr_data);
    end
    checks++;
    if (bus.alu_x !== 16'd7) begin failures++; $display("FAIL d_value: got %0d, expected 7", bus.alu_x); end
  endtask

  task automatic test_load_jump();
    rom.delete(); ram.delete();
    ram[100] = 16'hFFFF;
    rom[0] = 16'h0064;  // @100
    rom[1] = 16'hFC10;  // D=M
    rom[2] = 16'h0014;  // @20
    rom[3] = 16'hE304;  // D;JLT
    start_run(5);
    wait_done(400, "load_jump");
    checks++;
    if (bus.alu_x !== 16'hFFFF) begin failures++; $display("FAIL load_d: got %h, expected FFFF", bus.alu_x); end
    checks++;
    if (fetch_log.size() < 5 || fetch_log[4] !== 15'd20) begin
      failures++;
      $display("FAIL jlt_target: jump did not land at 20");
    end
  endtask

  task automatic test_pc_wrap();
    rom.delete(); ram.delete();
    rom[0]        = 16'h7FFF;  // @32767
    rom[1]        = 16'hEA87;  // 0;JMP
    rom[15'h7FFF] = 16'h0003;  // @3 at the top of the ROM
    start_run(5);
    wait_done(400, "pc_wrap");
    checks++;
    if (fetch_log.size() < 4 || fetch_log[2] !== 15'h7FFF || fetch_log[3] !== 15'h0000) begin
      failures++;
      $display("FAIL pc_wrap: fetch after 7FFF not at 0000");
    end
  endtask

  task automatic test_halt_loop();
    int cnt = 0;
    rom.delete(); ram.delete();
    rom[0]  = 16'h0009;  // @9
    rom[1]  = 16'hEA87;  // 0;JMP
    rom[9]  = 16'h0009;  // @9
    rom[10] = 16'hEA87;  // 0;JMP
    start_run(8);
    wait_done(400, "halt_loop");
    if (HALT_EN) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (bus.imem_req) cnt++;
      end
      checks++;
      if (halted !== 1'b1) begin failures++; $display("FAIL halted: got %b, expected 1", halted); end
      checks++;
      if (cnt !== 0) begin failures++; $display("FAIL halt_req: imem_req high %0d cycles, expected 0", cnt); end
      checks++;
      if (pc !== 15'd9 || fetch_log.size() !== 4) begin
        failures++;
        $display("FAIL halt_pc: pc=%0d fetches=%0d, expected 9 4", pc, fetch_log.size());
      end
    end else begin
      checks++;
      if (halted !== 1'b0) begin failures++; $display("FAIL halted: got %b, expected 0", halted); end
      checks++;
      if (fetch_log.size() < 8 || fetch_log[4] !== 15'd9 || fetch_log[5] !== 15'd10 ||
          fetch_log[6] !== 15'd9 || fetch_log[7] !== 15'd10) begin
        failures++;
        $display("FAIL loop_pc: loop does not alternate 9/10");
      end
    end
  endtask

  task automatic test_reset_mid_access();
    bit found = 1'b0;
    rom.delete(); ram.delete();
    rom[0] = 16'h0064;  // @100
    rom[1] = 16'hE7C8;  // M=D+1
    dmem_fix = 30;
    start_run(100);
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      found = bus.dmem_req;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL mid_wait: dmem_req never seen, expected 1"); end
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    checks++;
    if (bus.dmem_req !== 1'b0 || bus.dmem_we !== 1'b0 || bus.imem_req !== 1'b0 || pc !== 15'h0000) begin
      failures++;
      $display("FAIL mid_reset: dmem_req=%b we=%b imem_req=%b pc=%h, expected 0 0 0 0000",
               bus.dmem_req, bus.dmem_we, bus.imem_req, pc);
    end
    dmem_fix = -1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 15'h0000 || bus.dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL mid_restart: imem_req=%b addr=%h dmem_req=%b, expected 1 0000 0",
               bus.imem_req, bus.imem_addr, bus.dmem_req);
    end
  endtask

  task automatic test_random();
    for (int run = 0; run < 5; run++) begin
      rom.delete(); ram.delete();
      for (int i = 0; i < 64; i++) begin
        if ($urandom_range(0, 1) == 0) rom[15'(i)] = {10'b0, 6'($urandom_range(0, 63))};
        else                           rom[15'(i)] = {1'b1, 15'($urandom)};
        ram[15'(i)] = 16'($urandom);
      end
      start_run(40);
      wait_done(3000, "random");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_fetch_delay();
    test_load_jump();
    test_pc_wrap();
    test_halt_loop();
    test_reset_mid_access();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hack_ctrl.md
# hack_ctrl

Multi-cycle control unit for the HACK CPU. Fetches 16-bit HACK instructions over a request/acknowledge port, decodes them, drives the six ALU control bits and ALU operands to the combinational ALU, and reads the ALU results. Owns the A, D and PC registers and sequences data-memory reads and writes over a second request/acknowledge port. Sits between instruction ROM, data RAM and the ALU inside the CPU top level.

## Interface
- No parameters. Widths are fixed: 16-bit data, 15-bit addresses.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  15  fetch address (= PC)
- imem_ack  in  1  fetch data valid this cycle
- imem_data  in  16  instruction word
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  15  A[14:0]
- dmem_wdata  out  16  store data
- dmem_ack  in  1  access complete; read data valid this cycle
- dmem_rdata  in  16  load data
- alu_x  out  16  D register
- alu_y  out  16  A register or latched M
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  instruction bits [11:6], in that order
- alu_out  in  16  ALU result
- alu_zr  in  1  ALU zero flag
- alu_ng  in  1  ALU negative flag
- pc  out  15  current PC (debug)
- halted  out  1  halt-loop detected (see Configuration)

## Operation
- Instruction word: bit15 = 0 is an A-instruction. Otherwise it is a C-instruction with fields a = [12], c = [11:6], d = [5:3] (A, D, M), j = [2:0] (lt, eq, gt). Bits [14:13] are ignored.
- States: FETCH, DECODE, MREAD, EXEC, MWRITE, HALT.
- FETCH: hold imem_req = 1 with imem_addr = PC stable until imem_ack. On ack, latch imem_data into IR, then go to DECODE.
- DECODE, A-instruction: A <= {0, IR[14:0]}, PC <= PC+1, then go to FETCH.
- DECODE, C-instruction: if a = 1 go to MREAD, else go to EXEC.
- MREAD: hold dmem_req = 1, dmem_we = 0, dmem_addr = A until dmem_ack. Latch dmem_rdata into M, then go to EXEC.
- EXEC:
  - alu_y = M if a = 1, else A. Control bits are driven from IR only in EXEC and are 0 in every other state.
  - Results are sampled the same cycle and the ALU result is latched into R.
  - Stores: d1 updates A, d2 updates D.
  - Jump taken = (j1 & ng) | (j2 & zr) | (j3 & ~ng & ~zr).
  - PC <= taken ? old A[14:0] : PC+1. The jump uses the pre-update A.
  - Next state is MWRITE if d3 = 1, else FETCH.
- MWRITE: hold dmem_req = 1, dmem_we = 1, dmem_addr = pre-EXEC A[14:0], dmem_wdata = R until dmem_ack, then go to FETCH. The store address is the A value from before EXEC, captured in a shadow register.
- PC arithmetic is modulo 2^15: PC+1 at 0x7FFF wraps to 0x0000.
- Request outputs are driven directly from state registers, with no combinational path from ack to req.

## Timing
- Reset (asynchronous, takes effect immediately): A = D = PC = IR = M = R = 0, state = FETCH, all req/we/alu_* outputs and halted = 0. Reset in the middle of an access abandons it; a late ack after release is ignored unless it arrives during the new FETCH.
- Minimum latency, with ack in the same cycle as req:
  - A-instruction: 2 cycles.
  - C-instruction: 3 cycles.
  - Add 1 cycle for an M read and 1 cycle for an M write.
- Each wait cycle without ack adds 1 cycle. There is no timeout.
- A C-instruction with a = 1 and d3 = 1 issues the read, then the write, to the same address.

## Configuration
- HACK_CTRL_HALT_EN defined:
  - In EXEC, a taken jump whose target equals PC−1, where the previous instruction was an A-instruction, enters HALT.
  - In HALT: halted = 1, no further requests are issued, registers are frozen. Only reset exits HALT.
- HACK_CTRL_HALT_EN undefined: the HALT state does not exist, halted is tied 0, and the loop runs forever.

## Structure
- Package hack_pkg holds:
  - the state enum;
  - field-position constants (A_BIT = 12, C_MSB = 11, C_LSB = 6, D_A = 5, D_D = 4, D_M = 3, J_LT = 2, J_EQ = 1, J_GT = 0);
  - the reset PC constant.
- One sub-module, hack_jump_unit: combinational taken-decision from j[2:0], zr and ng.

## Test plan
- Reset, then fetch @5 (0x0005) with ack delayed 3 cycles -> A = 5, PC = 1, imem_req held high for 4 cycles with imem_addr = 0.
- @7; D=A (0xEC10) -> alu_zx..no = 110000 in EXEC, D = 7, PC = 2.
- @100; M=D+1 (0xE7C8) with D = 7 -> dmem write addr 100, data 8, dmem_we = 1.
- @100; D=M (0xFC10) with RAM[100] = 0xFFFF -> D = 0xFFFF. Then D;JLT (0xE304) with A = 20 -> PC = 20.
- At PC = 0x7FFF, an A-instruction -> PC wraps to 0x0000.
- @9 at PC 9, then 0;JMP at PC 10 -> with HACK_CTRL_HALT_EN, halted = 1 and imem_req stays 0. Without the macro, PC alternates 9, 10 indefinitely. Reset asserted during a pending dmem_req drops it within the same cycle.
